// File: rtl/fusion_regfile_pkg.sv
// Shared definitions for the banked register file: bank IDs, clear FSM states, half-mask encoding.
// Optional write-to-read forwarding is selected in the top level by FUSION_RF_BYPASS_EN.
package fusion_regfile_pkg;

    localparam int BANK_GP  = 0;
    localparam int BANK_SYS = 1;
    localparam int BANK_GBL = 2;

    typedef logic [0:0] clr_state_t;
    localparam clr_state_t ST_IDLE  = 1'b0;
    localparam clr_state_t ST_CLEAR = 1'b1;

    // Half mask is {hi, low}; the all-zero mask is a full-word write, not a no-op.
    localparam logic [1:0] MASK_FULL = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b01;
    localparam logic [1:0] MASK_HI   = 2'b10;
    localparam logic [1:0] MASK_BOTH = 2'b11;

    function automatic logic [1:0] expand_mask(input logic [1:0] mask);
        return (mask == MASK_FULL) ? MASK_BOTH : mask;
    endfunction

endpackage

// File: rtl/fusion_rf_bank.sv
// One register bank: 2**ADDR_W entries, two async read ports, one half-masked write port and a clear port.
// A write to the entry being cleared wins; its disabled halves see the cleared (zero) value.
module fusion_rf_bank
    import fusion_regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_IDX = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        wmask,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int HALF  = DATA_W / 2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        half_en;

    assign half_en = expand_mask(wmask);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic              hit_wr;
            logic              hit_clr;
            logic [DATA_W-1:0] base;
            logic [DATA_W-1:0] entry_next;
            logic [DATA_W-1:0] entry_reg;

            assign hit_wr  = we && (waddr == ADDR_W'(gi)) && !(ZERO_IDX && (gi == 0));
            assign hit_clr = clr_en && (clr_addr == ADDR_W'(gi));
            assign base    = hit_clr ? '0 : entry_reg;
            assign entry_next = {half_en[1] ? wdata[DATA_W-1:HALF] : base[DATA_W-1:HALF],
                                 half_en[0] ? wdata[HALF-1:0]      : base[HALF-1:0]};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (hit_wr) begin
                    entry_reg <= entry_next;
                end else if (hit_clr) begin
                    entry_reg <= '0;
                end
            end

            assign mem[gi] = entry_reg;
        end
    endgenerate

    assign rdata_a = (ZERO_IDX && (raddr_a == '0)) ? '0 : mem[raddr_a];
    assign rdata_b = (ZERO_IDX && (raddr_b == '0)) ? '0 : mem[raddr_b];

endmodule

// File: rtl/fusion_banked_regfile.sv
// Multi-bank register file top: bank decode, registered read ports, sticky bad-bank flag, clear FSM.
// Define FUSION_RF_BYPASS_EN for same-cycle write/clear forwarding; otherwise reads see pre-write data.
module fusion_banked_regfile
    import fusion_regfile_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_BANKS = 3,
    parameter int BANK_W    = 2,
    parameter int ZERO_REG  = 1
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [BANK_W-1:0] bank_sel_in,
    input  logic              rs_req_in,
    input  logic [ADDR_W-1:0] rsa_in,
    input  logic [ADDR_W-1:0] rsb_in,
    output logic [DATA_W-1:0] rsa_val_out,
    output logic [DATA_W-1:0] rsb_val_out,
    output logic              rs_valid_out,
    input  logic              wb_in,
    input  logic [BANK_W-1:0] wb_bank_sel_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0] rd_val_in,
    input  logic              hi_in,
    input  logic              low_in,
    input  logic              clr_req_in,
    input  logic [BANK_W-1:0] clr_bank_in,
    output logic              busy_out,
    output logic              bank_err_out
);

    function automatic logic bank_valid(input logic [BANK_W-1:0] bank);
        return {1'b0, bank} < (BANK_W+1)'(NUM_BANKS);
    endfunction

    logic [DATA_W-1:0] bank_rd_a [NUM_BANKS];
    logic [DATA_W-1:0] bank_rd_b [NUM_BANKS];

    clr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;
    logic [BANK_W-1:0] clr_bank_reg, clr_bank_next;
    logic              busy;

    logic [DATA_W-1:0] rsa_reg, rsb_reg;
    logic              valid_reg;
    logic              err_reg;

    logic [DATA_W-1:0] rd_a, rd_b, rd_a_next, rd_b_next;
    logic              rd_bank_ok, wb_bank_ok, clr_bank_ok, err_set;

    assign busy        = (state_reg == ST_CLEAR);
    assign rd_bank_ok  = bank_valid(bank_sel_in);
    assign wb_bank_ok  = bank_valid(wb_bank_sel_in);
    assign clr_bank_ok = bank_valid(clr_bank_in);

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            fusion_rf_bank #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .ZERO_IDX((ZERO_REG != 0) && (gi == BANK_GP))
            ) u_bank (
                .clk     (clk_in),
                .rst     (reset_in),
                .raddr_a (rsa_in),
                .raddr_b (rsb_in),
                .rdata_a (bank_rd_a[gi]),
                .rdata_b (bank_rd_b[gi]),
                .we      (wb_in && (wb_bank_sel_in == BANK_W'(gi))),
                .waddr   (rd_in),
                .wdata   (rd_val_in),
                .wmask   ({hi_in, low_in}),
                .clr_en  (busy && (clr_bank_reg == BANK_W'(gi))),
                .clr_addr(clr_ptr_reg)
            );
        end
    endgenerate

`ifdef FUSION_RF_BYPASS_EN
    localparam int HALF = DATA_W / 2;

    function automatic logic [DATA_W-1:0] merge_halves(input logic [DATA_W-1:0] old_val,
                                                       input logic [DATA_W-1:0] new_val,
                                                       input logic [1:0]        en);
        return {en[1] ? new_val[DATA_W-1:HALF] : old_val[DATA_W-1:HALF],
                en[0] ? new_val[HALF-1:0]      : old_val[HALF-1:0]};
    endfunction

    logic fwd_clr, fwd_wb, wb_dropped;
    assign fwd_clr    = busy && rd_bank_ok && (clr_bank_reg == bank_sel_in);
    assign wb_dropped = (ZERO_REG != 0) && (wb_bank_sel_in == BANK_W'(BANK_GP)) && (rd_in == '0);
    assign fwd_wb     = wb_in && rd_bank_ok && (wb_bank_sel_in == bank_sel_in) && !wb_dropped;
`endif

    // Unimplemented banks leave rd_a/rd_b at zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_sel_in == BANK_W'(b)) begin
                rd_a = bank_rd_a[b];
                rd_b = bank_rd_b[b];
            end
        end
        rd_a_next = rd_a;
        rd_b_next = rd_b;
`ifdef FUSION_RF_BYPASS_EN
        if (fwd_clr && (rsa_in == clr_ptr_reg)) rd_a_next = '0;
        if (fwd_clr && (rsb_in == clr_ptr_reg)) rd_b_next = '0;
        if (fwd_wb && (rsa_in == rd_in))
            rd_a_next = merge_halves(rd_a_next, rd_val_in, expand_mask({hi_in, low_in}));
        if (fwd_wb && (rsb_in == rd_in))
            rd_b_next = merge_halves(rd_b_next, rd_val_in, expand_mask({hi_in, low_in}));
`endif
    end

    always_comb begin
        state_next    = state_reg;
        clr_ptr_next  = clr_ptr_reg;
        clr_bank_next = clr_bank_reg;
        if (state_reg == ST_IDLE) begin
            if (clr_req_in && clr_bank_ok) begin
                state_next    = ST_CLEAR;
                clr_ptr_next  = '0;
                clr_bank_next = clr_bank_in;
            end
        end else begin
            if (clr_ptr_reg == '1) begin
                state_next = ST_IDLE;
            end else begin
                clr_ptr_next = clr_ptr_reg + 1'b1;
            end
        end
    end

    // A clear request while busy is ignored entirely, including its bank check.
    assign err_set = (rs_req_in && !rd_bank_ok) ||
                     (wb_in && !wb_bank_ok) ||
                     (clr_req_in && !busy && !clr_bank_ok);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_reg    <= ST_IDLE;
            clr_ptr_reg  <= '0;
            clr_bank_reg <= '0;
            rsa_reg      <= '0;
            rsb_reg      <= '0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_ptr_reg  <= clr_ptr_next;
            clr_bank_reg <= clr_bank_next;
            err_reg      <= err_reg | err_set;
            valid_reg    <= rs_req_in;
            if (rs_req_in) begin
                rsa_reg <= rd_a_next;
                rsb_reg <= rd_b_next;
            end
        end
    end

    assign rsa_val_out  = rsa_reg;
    assign rsb_val_out  = rsb_reg;
    assign rs_valid_out = valid_reg;
    assign busy_out     = busy;
    assign bank_err_out = err_reg;

endmodule

// File: tb/tb_fusion_banked_regfile.sv
// Directed scoreboard bench for fusion_banked_regfile; expected bypass result follows FUSION_RF_BYPASS_EN.
module tb_fusion_banked_regfile;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [1:0]  bank_sel_in;
    logic        rs_req_in;
    logic [4:0]  rsa_in, rsb_in;
    logic [31:0] rsa_val_out, rsb_val_out;
    logic        rs_valid_out;
    logic        wb_in;
    logic [1:0]  wb_bank_sel_in;
    logic [4:0]  rd_in;
    logic [31:0] rd_val_in;
    logic        hi_in, low_in;
    logic        clr_req_in;
    logic [1:0]  clr_bank_in;
    logic        busy_out, bank_err_out;

    fusion_banked_regfile dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .bank_sel_in   (bank_sel_in),
        .rs_req_in     (rs_req_in),
        .rsa_in        (rsa_in),
        .rsb_in        (rsb_in),
        .rsa_val_out   (rsa_val_out),
        .rsb_val_out   (rsb_val_out),
        .rs_valid_out  (rs_valid_out),
        .wb_in         (wb_in),
        .wb_bank_sel_in(wb_bank_sel_in),
        .rd_in         (rd_in),
        .rd_val_in     (rd_val_in),
        .hi_in         (hi_in),
        .low_in        (low_in),
        .clr_req_in    (clr_req_in),
        .clr_bank_in   (clr_bank_in),
        .busy_out      (busy_out),
        .bank_err_out  (bank_err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [1:0] bk, input logic [4:0] idx, input logic [31:0] data,
                      input logic hi, input logic lo);
        wb_in = 1'b1; wb_bank_sel_in = bk; rd_in = idx; rd_val_in = data; hi_in = hi; low_in = lo;
        step();
        wb_in = 1'b0; hi_in = 1'b0; low_in = 1'b0;
    endtask

    // Drives one read request, pushes its expectation, then pops and compares the registered result.
    task automatic rd(input logic [1:0] bk, input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] ea, input logic [31:0] eb, input string tag);
        exp_t e;
        bank_sel_in = bk; rsa_in = a; rsb_in = b; rs_req_in = 1'b1;
        sb.push_back('{tag, ea, eb});
        step();
        rs_req_in = 1'b0;
        chk({tag, "_valid"}, {31'd0, rs_valid_out}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            $display("read %s bank=%0d a[%0d]=%h b[%0d]=%h", e.tag, bk, a, rsa_val_out, b, rsb_val_out);
            chk({e.tag, "_a"}, rsa_val_out, e.a);
            chk({e.tag, "_b"}, rsb_val_out, e.b);
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] ea, eb;

        reset_in = 1'b1; bank_sel_in = '0; rs_req_in = 1'b0; rsa_in = '0; rsb_in = '0;
        wb_in = 1'b0; wb_bank_sel_in = '0; rd_in = '0; rd_val_in = '0; hi_in = 1'b0; low_in = 1'b0;
        clr_req_in = 1'b0; clr_bank_in = '0;
        repeat (3) step();
        chk("rst_valid", {31'd0, rs_valid_out}, 32'd0);
        chk("rst_rsa", rsa_val_out, 32'd0);
        chk("rst_rsb", rsb_val_out, 32'd0);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_err", {31'd0, bank_err_out}, 32'd0);
        reset_in = 1'b0;
        step();

        rd(2'd1, 5'd3, 5'd4, 32'd0, 32'd0, "rst_read");

        // Half-masked writes to bank 0 index 5, then a full-mask (11) write to index 6.
        wr(2'd0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        wr(2'd0, 5'd5, 32'h12345678, 1'b1, 1'b0);
        rd(2'd0, 5'd5, 5'd5, 32'h1234BEEF, 32'h1234BEEF, "hi_only");
        step();
        chk("valid_drop", {31'd0, rs_valid_out}, 32'd0);
        chk("hold_rsa", rsa_val_out, 32'h1234BEEF);
        wr(2'd0, 5'd5, 32'hAAAA5555, 1'b0, 1'b1);
        wr(2'd0, 5'd6, 32'hCAFEF00D, 1'b1, 1'b1);
        rd(2'd0, 5'd5, 5'd6, 32'h12345555, 32'hCAFEF00D, "lo_and_both");

        wr(2'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        wr(2'd2, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        rd(2'd0, 5'd0, 5'd5, 32'd0, 32'h12345555, "zero_reg");
        rd(2'd2, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "gbl_idx0");
        chk("err_before_bad", {31'd0, bank_err_out}, 32'd0);

        rd(2'd3, 5'd1, 5'd2, 32'd0, 32'd0, "bad_bank");
        chk("err_set", {31'd0, bank_err_out}, 32'd1);
        wr(2'd1, 5'd1, 32'h00000077, 1'b0, 1'b0);
        rd(2'd1, 5'd1, 5'd1, 32'h00000077, 32'h00000077, "legal_after_bad");
        chk("err_sticky", {31'd0, bank_err_out}, 32'd1);

        for (int i = 0; i < 32; i++) wr(2'd1, 5'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
        rd(2'd1, 5'd10, 5'd31, 32'h10A, 32'h11F, "fill");

        // Clear bank 1; the pointer equals cyc while counting, so cyc 10 collides with index 10.
        clr_req_in = 1'b1; clr_bank_in = 2'd1;
        step();
        clr_req_in = 1'b0;
        chk("clr_busy_start", {31'd0, busy_out}, 32'd1);
        cyc = 0;
        while (busy_out && cyc < 100) begin
            if (cyc == 10) begin
                wb_in = 1'b1; wb_bank_sel_in = 2'd1; rd_in = 5'd10; rd_val_in = 32'hA5;
            end else begin
                wb_in = 1'b0;
            end
            step();
            cyc++;
        end
        wb_in = 1'b0;
        chk("clr_cycles", 32'(cyc), 32'd32);
        for (int i = 0; i < 32; i += 2) begin
            ea = (i == 10) ? 32'hA5 : 32'd0;
            eb = 32'd0;
            rd(2'd1, 5'(i), 5'(i + 1), ea, eb, $sformatf("cleared_%0d", i));
        end

        wr(2'd2, 5'd7, 32'h11, 1'b0, 1'b0);
        wb_in = 1'b1; wb_bank_sel_in = 2'd2; rd_in = 5'd7; rd_val_in = 32'h55;
`ifdef FUSION_RF_BYPASS_EN
        rd(2'd2, 5'd7, 5'd8, 32'h55, 32'd0, "same_cycle");
`else
        rd(2'd2, 5'd7, 5'd8, 32'h11, 32'd0, "same_cycle");
`endif
        wb_in = 1'b0;
        rd(2'd2, 5'd7, 5'd7, 32'h55, 32'h55, "after_write");

        clr_req_in = 1'b1; clr_bank_in = 2'd2;
        step();
        clr_req_in = 1'b0;
        repeat (5) step();
        chk("mid_clr_busy", {31'd0, busy_out}, 32'd1);
        reset_in = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy_out}, 32'd0);
        chk("abort_err", {31'd0, bank_err_out}, 32'd0);
        chk("abort_valid", {31'd0, rs_valid_out}, 32'd0);
        step();
        reset_in = 1'b0;
        step();
        chk("post_rst_busy", {31'd0, busy_out}, 32'd0);
        rd(2'd2, 5'd7, 5'd0, 32'd0, 32'd0, "post_rst_gbl");
        rd(2'd0, 5'd5, 5'd6, 32'd0, 32'd0, "post_rst_gp");
        rd(2'd1, 5'd10, 5'd1, 32'd0, 32'd0, "post_rst_sys");

        clr_req_in = 1'b1; clr_bank_in = 2'd3;
        step();
        clr_req_in = 1'b0;
        chk("bad_clr_busy", {31'd0, busy_out}, 32'd0);
        chk("bad_clr_err", {31'd0, bank_err_out}, 32'd1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
